interrupt_arbiter: RTL and testbench
====================================

// Module: interrupt_arbiter
// PURPOSE
//  Collects UART interrupt events, masks them with the ISR enable bits, and latches them as pending.
//  Picks the highest-priority pending source, then drives the ISR INTID field
//  (interrupt_id_o / interrupt_id_en_o), the CTR INTPEND bit (int_pend_o) and the CPU request line.
//  Holds each interrupt until the CPU acknowledges it through ISR.IACK.
//  Sits directly upstream of configuration_registers.
// PARAMETERS
//  TIMEOUT_TICKS  640  baud ticks with no RX activity before the RX timeout interrupt (4 chars x 10 bits x 16)
//  FIFO_DEPTH     64   RX FIFO depth; sets the width of rx_fifo_count_i
// PORTS
//  clk_i                i  1   system clock
//  rst_n_i              i  1   asynchronous active-low reset
//  overrun_error_i      i  1   1-cycle pulse: RX overrun
//  parity_error_i       i  1   1-cycle pulse: RX parity error
//  frame_error_i        i  1   1-cycle pulse: RX framing error
//  config_req_i         i  1   1-cycle pulse: configuration request received from the link
//  tx_done_i            i  1   1-cycle pulse: TX FIFO drained and transmitter idle
//  rx_fifo_count_i      i  7   RX FIFO occupancy
//  rx_fifo_threshold_i  i  6   from FSR.RX_TRESHOLD
//  rx_fifo_read_i       i  1   CPU pops RX FIFO
//  rx_push_i            i  1   RX pushes a byte into the FIFO
//  bit_tick_i           i  1   oversampling baud tick
//  rx_rdy_en_i, frame_error_en_i, parity_error_en_i, overrun_error_en_i  i 1 each  ISR enables
//  int_ackn_i           i  1   ISR.IACK level; its rising edge is the acknowledge
//  interrupt_id_o       o  3   serviced source ID
//  interrupt_id_en_o    o  1   1-cycle load strobe for ISR.INTID
//  int_pend_o           o  1   an interrupt is being serviced
//  ireq_n_o             o  1   active-low CPU interrupt request
// BEHAVIOUR
//  Reset values: interrupt_id_o=3'b000 (INT_NONE), interrupt_id_en_o=0, int_pend_o=0, ireq_n_o=1.
//  Reset clears every pending flag, the timeout counter and the FSM.
//  Sources, ID and priority (1 = highest):
//   OVR 001 > PAR 010 > FRM 011 > RXTO 100 > RXRDY 101 > CFG 110 > TXD 111.
//  Edge sources OVR, PAR, FRM, CFG, TXD:
//   - event pulse sets a sticky pending flag; OVR, PAR and FRM also require their enable.
//   - clearing the enable clears the pending flag on the next cycle.
//   - set and clear in the same cycle: set wins.
//  RXRDY is a level source: pending = rx_rdy_en_i & (count >= threshold) & (count != 0).
//   It is never cleared by ack; it re-raises after ack while the condition still holds.
//  FSM IDLE -> SERVE -> WAIT_ACK -> IDLE:
//   - IDLE: if any pending, capture the highest ID; next state SERVE.
//   - SERVE (1 cycle): interrupt_id_en_o=1, int_pend_o=1, ireq_n_o=0. Request latency = 2 cycles from the event pulse.
//   - WAIT_ACK: hold int_pend_o=1 and ireq_n_o=0. Higher-priority arrivals stay pending only; no preemption.
//   - Ack edge (internal edge_detector on int_ackn_i): clear the served edge flag, set ireq_n_o=1 and int_pend_o=0, go to IDLE.
//   - An ack edge in IDLE or SERVE is ignored.
//   - If the served source's enable drops during WAIT_ACK, service still completes on ack.
//   - Back-to-back: the next pending source is served 1 cycle after returning to IDLE.
//  interrupt_id_o holds the last served ID until the next SERVE.
//  Reset asserted mid-WAIT_ACK: immediate return to reset values.
// CONFIGURATION
//  RX_TIMEOUT_EN defined:
//   - Counter counts bit_tick_i while count != 0.
//   - Zeroes on rx_push_i, on rx_fifo_read_i, or when count == 0; saturates at TIMEOUT_TICKS.
//   - Reaching TIMEOUT_TICKS sets RXTO pending, gated by rx_rdy_en_i.
//   - RXTO clears on ack and on counter reset.
//  RX_TIMEOUT_EN undefined: no counter; RXTO is never pending; ID 100 never issued; bit_tick_i unused.
// STRUCTURE
//  UART_pkg:
//   - uart_int_id_t enum (INT_NONE, INT_OVR .. INT_TXD).
//   - arbiter_state_t enum (IDLE, SERVE, WAIT_ACK).
//   - STD_TIMEOUT_TICKS constant.
//  Priority encoder as an always_comb casez inside the module.
//  Sub-modules:
//   - reuses existing edge_detector for the ack edge.
//   - one new sub-module, rx_timeout_counter, exists only under RX_TIMEOUT_EN.
// TESTING
//  - PAR pulse with parity_error_en_i=1 -> 2 cycles later: ireq_n_o=0, id=010, id_en one cycle; ack edge -> ireq_n_o=1 next cycle.
//  - OVR and TXD pulsed same cycle -> id=001 served first; after ack, id=111 served 1 cycle after IDLE.
//  - threshold=8, push 8 bytes with rx_rdy_en_i=1 -> id=101. Ack with count=8 -> re-raised; read to 7, ack -> stays idle.
//  - FRM pulse with frame_error_en_i=0 -> no request. Enable=1, pulse, then disable before IDLE capture -> no request.
//  - RX_TIMEOUT_EN: 1 byte in FIFO, 640 ticks with no push/read -> id=100. A read at tick 639 -> no interrupt.
//  - rst_n_i low during WAIT_ACK -> outputs at reset values asynchronously; a stale ack after reset -> no effect.

Source files
------------

// File: rtl/interrupt_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// interrupt_arbiter_pkg
// Shared types and constants for the UART interrupt arbiter.
//   uart_int_id_t      : interrupt source IDs as written into ISR.INTID
//                        (lower non-zero value = higher priority)
//   arbiter_state_t    : states of the service FSM
//   STD_TIMEOUT_TICKS  : baud ticks of RX silence before an RX timeout
//                        (4 characters x 10 bits x 16x oversampling)
//   STD_FIFO_DEPTH     : RX FIFO depth, sets the occupancy/threshold widths
// ----------------------------------------------------------------------------
package interrupt_arbiter_pkg;

    localparam int STD_TIMEOUT_TICKS = 640;
    localparam int STD_FIFO_DEPTH    = 64;

    typedef enum logic [2:0] {
        INT_NONE  = 3'b000,
        INT_OVR   = 3'b001,
        INT_PAR   = 3'b010,
        INT_FRM   = 3'b011,
        INT_RXTO  = 3'b100,
        INT_RXRDY = 3'b101,
        INT_CFG   = 3'b110,
        INT_TXD   = 3'b111
    } uart_int_id_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SERVE    = 2'd1,
        WAIT_ACK = 2'd2
    } arbiter_state_t;

endpackage

// File: rtl/interrupt_arbiter_if.sv
// ----------------------------------------------------------------------------
// interrupt_arbiter_if
// Bundles the event, FIFO-status, enable, acknowledge and ISR/CPU-facing
// signals of the interrupt arbiter. Signal suffixes are from the arbiter's
// point of view.
//   slave  : the arbiter (consumes *_i, drives *_o)
//   master : the UART datapath / register block driving the arbiter
// Parameter FIFO_DEPTH sets rx_fifo_count_i (log2+1 bits) and
// rx_fifo_threshold_i (log2 bits).
// ----------------------------------------------------------------------------
interface interrupt_arbiter_if #(
    parameter int FIFO_DEPTH = 64
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int TW = $clog2(FIFO_DEPTH);

    logic          overrun_error_i;
    logic          parity_error_i;
    logic          frame_error_i;
    logic          config_req_i;
    logic          tx_done_i;
    logic [CW-1:0] rx_fifo_count_i;
    logic [TW-1:0] rx_fifo_threshold_i;
    logic          rx_fifo_read_i;
    logic          rx_push_i;
    logic          bit_tick_i;
    logic          rx_rdy_en_i;
    logic          frame_error_en_i;
    logic          parity_error_en_i;
    logic          overrun_error_en_i;
    logic          int_ackn_i;
    logic [2:0]    interrupt_id_o;
    logic          interrupt_id_en_o;
    logic          int_pend_o;
    logic          ireq_n_o;

    modport slave (
        input  overrun_error_i, parity_error_i, frame_error_i, config_req_i, tx_done_i,
        input  rx_fifo_count_i, rx_fifo_threshold_i, rx_fifo_read_i, rx_push_i, bit_tick_i,
        input  rx_rdy_en_i, frame_error_en_i, parity_error_en_i, overrun_error_en_i,
        input  int_ackn_i,
        output interrupt_id_o, interrupt_id_en_o, int_pend_o, ireq_n_o
    );

    modport master (
        output overrun_error_i, parity_error_i, frame_error_i, config_req_i, tx_done_i,
        output rx_fifo_count_i, rx_fifo_threshold_i, rx_fifo_read_i, rx_push_i, bit_tick_i,
        output rx_rdy_en_i, frame_error_en_i, parity_error_en_i, overrun_error_en_i,
        output int_ackn_i,
        input  interrupt_id_o, interrupt_id_en_o, int_pend_o, ireq_n_o
    );

endinterface

// File: rtl/edge_detector.sv
// ----------------------------------------------------------------------------
// edge_detector
// Rising-edge detector on a level signal already synchronous to clk_i.
//   clk_i   : clock
//   rst_n_i : asynchronous active-low reset (previous level cleared to 0)
//   sig_i   : level input
//   rise_o  : high for the cycle in which sig_i is 1 and was 0 last cycle
// ----------------------------------------------------------------------------
module edge_detector (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic sig_i,
    output logic rise_o
);

    logic prev_q;

    // Remember last cycle's level so a rise can be seen combinationally in
    // the cycle it arrives; the consumer acts on it at the very next edge.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= sig_i;
        end
    end

    assign rise_o = sig_i & ~prev_q;

endmodule

// File: rtl/rx_timeout_counter.sv
// ----------------------------------------------------------------------------
// rx_timeout_counter  (built only when RX_TIMEOUT_EN is defined)
// Counts baud ticks of RX inactivity while the RX FIFO holds data.
//   clk_i, rst_n_i   : clock, asynchronous active-low reset
//   bit_tick_i       : oversampling baud tick
//   rx_push_i        : RX wrote a byte (activity, restarts the count)
//   rx_fifo_read_i   : CPU popped a byte (activity, restarts the count)
//   rx_fifo_count_i  : FIFO occupancy; empty FIFO holds the count at zero
//   timeout_o        : one-cycle pulse in the cycle the count hits the limit
//   clear_o          : the count is being zeroed this cycle
// Parameters: TIMEOUT_TICKS (limit, saturating), CW (occupancy width).
// ----------------------------------------------------------------------------
`ifdef RX_TIMEOUT_EN
module rx_timeout_counter #(
    parameter int TIMEOUT_TICKS = 640,
    parameter int CW            = 7
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          bit_tick_i,
    input  logic          rx_push_i,
    input  logic          rx_fifo_read_i,
    input  logic [CW-1:0] rx_fifo_count_i,
    output logic          timeout_o,
    output logic          clear_o
);

    localparam int NW = $clog2(TIMEOUT_TICKS + 1);
    localparam logic [NW-1:0] LIMIT = NW'(TIMEOUT_TICKS);

    logic [NW-1:0] cnt_q;
    logic [NW-1:0] cnt_d;

    // Any FIFO activity or an empty FIFO restarts the silence measurement;
    // otherwise each tick advances the count until it parks at the limit.
    always_comb begin
        clear_o = rx_push_i | rx_fifo_read_i | (rx_fifo_count_i == '0);
        cnt_d   = cnt_q;
        if (clear_o) begin
            cnt_d = '0;
        end else if (bit_tick_i && (cnt_q != LIMIT)) begin
            cnt_d = cnt_q + 1'b1;
        end
        timeout_o = (cnt_q != LIMIT) && (cnt_d == LIMIT);
    end

    // Count register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule
`endif

// File: rtl/interrupt_arbiter.sv
// ----------------------------------------------------------------------------
// interrupt_arbiter
// Latches UART interrupt events as pending, serves the highest-priority one
// to the CPU and holds it until ISR.IACK rises.
//   clk_i, rst_n_i : clock, asynchronous active-low reset
//   bus (slave)    : event pulses (overrun/parity/frame/config/tx_done),
//                    RX FIFO status (count, threshold, push, read, bit tick),
//                    ISR enables, ISR.IACK level, and the outputs
//                    interrupt_id_o / interrupt_id_en_o (ISR.INTID load),
//                    int_pend_o (CTR.INTPEND) and ireq_n_o (CPU request)
// Priority: OVR > PAR > FRM > RXTO > RXRDY > CFG > TXD.
// Optional feature macro: RX_TIMEOUT_EN adds the RX timeout source (ID 100);
// without it that source is never pending and bit_tick_i is unused.
// ----------------------------------------------------------------------------
module interrupt_arbiter
    import interrupt_arbiter_pkg::*;
#(
    parameter int TIMEOUT_TICKS = STD_TIMEOUT_TICKS,
    parameter int FIFO_DEPTH    = STD_FIFO_DEPTH
) (
    input logic                clk_i,
    input logic                rst_n_i,
    interrupt_arbiter_if.slave bus
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    arbiter_state_t state_q, state_d;
    uart_int_id_t   id_q, id_d;
    uart_int_id_t   topId;

    logic ovrPend_q, ovrPend_d;
    logic parPend_q, parPend_d;
    logic frmPend_q, frmPend_d;
    logic cfgPend_q, cfgPend_d;
    logic txdPend_q, txdPend_d;

    logic          ackEdge;
    logic          ackDone;
    logic          capture;
    logic          rxtoReq;
    logic          rxRdyReq;
    logic [CW-1:0] rxCount;
    logic [6:0]    reqVec;
    logic          clrOvr, clrPar, clrFrm, clrRxto, clrCfg, clrTxd;

    edge_detector u_ackEdge (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .sig_i   (bus.int_ackn_i),
        .rise_o  (ackEdge)
    );

    // RX ready is a pure level: it stays asserted as long as the FIFO is at
    // or above threshold, which is why it re-raises after every ack.
    assign rxCount  = bus.rx_fifo_count_i;
    assign rxRdyReq = bus.rx_rdy_en_i
                    && (rxCount >= CW'(bus.rx_fifo_threshold_i))
                    && (rxCount != '0);

`ifdef RX_TIMEOUT_EN
    logic timeoutHit;
    logic timeoutClr;
    logic rxtoPend_q, rxtoPend_d;

    rx_timeout_counter #(
        .TIMEOUT_TICKS (TIMEOUT_TICKS),
        .CW            (CW)
    ) u_rxTimeout (
        .clk_i           (clk_i),
        .rst_n_i         (rst_n_i),
        .bit_tick_i      (bus.bit_tick_i),
        .rx_push_i       (bus.rx_push_i),
        .rx_fifo_read_i  (bus.rx_fifo_read_i),
        .rx_fifo_count_i (rxCount),
        .timeout_o       (timeoutHit),
        .clear_o         (timeoutClr)
    );

    // The timeout flag is sticky until served or until RX activity restarts
    // the silence count; a new hit in the same cycle still wins.
    always_comb begin
        rxtoPend_d = (timeoutHit & bus.rx_rdy_en_i)
                   | (rxtoPend_q & ~clrRxto & ~timeoutClr);
    end

    // Timeout pending register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rxtoPend_q <= 1'b0;
        end else begin
            rxtoPend_q <= rxtoPend_d;
        end
    end

    assign rxtoReq = rxtoPend_q;
`else
    localparam int unusedTimeoutTicks = TIMEOUT_TICKS;
    logic unusedRxTiming;

    assign rxtoReq        = 1'b0;
    assign unusedRxTiming = bus.bit_tick_i ^ bus.rx_push_i ^ bus.rx_fifo_read_i ^ clrRxto;
`endif

    // Error flags are qualified by their enable at arbitration time, so a
    // source disabled before the IDLE capture is never served.
    assign reqVec = {ovrPend_q & bus.overrun_error_en_i,
                     parPend_q & bus.parity_error_en_i,
                     frmPend_q & bus.frame_error_en_i,
                     rxtoReq,
                     rxRdyReq,
                     cfgPend_q,
                     txdPend_q};

    // Fixed-priority encoder: leftmost request bit is the most urgent.
    always_comb begin
        topId = INT_NONE;
        casez (reqVec)
            7'b1??????: topId = INT_OVR;
            7'b01?????: topId = INT_PAR;
            7'b001????: topId = INT_FRM;
            7'b0001???: topId = INT_RXTO;
            7'b00001??: topId = INT_RXRDY;
            7'b000001?: topId = INT_CFG;
            7'b0000001: topId = INT_TXD;
            default:    topId = INT_NONE;
        endcase
    end

    // Service FSM. The ID is frozen at the IDLE capture and only the served
    // source is cleared on ack, so later arrivals (even higher priority) just
    // wait their turn. Ack edges outside WAIT_ACK are deliberately dropped.
    always_comb begin
        state_d               = state_q;
        id_d                  = id_q;
        capture               = 1'b0;
        ackDone               = 1'b0;
        bus.interrupt_id_en_o = 1'b0;
        bus.int_pend_o        = 1'b0;
        bus.ireq_n_o          = 1'b1;
        case (state_q)
            IDLE: begin
                if (reqVec != '0) begin
                    capture = 1'b1;
                    id_d    = topId;
                    state_d = SERVE;
                end
            end
            SERVE: begin
                bus.interrupt_id_en_o = 1'b1;
                bus.int_pend_o        = 1'b1;
                bus.ireq_n_o          = 1'b0;
                state_d               = WAIT_ACK;
            end
            WAIT_ACK: begin
                bus.int_pend_o = 1'b1;
                bus.ireq_n_o   = 1'b0;
                if (ackEdge) begin
                    ackDone = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.interrupt_id_o = id_q;

    assign clrOvr  = ackDone && (id_q == INT_OVR);
    assign clrPar  = ackDone && (id_q == INT_PAR);
    assign clrFrm  = ackDone && (id_q == INT_FRM);
    assign clrRxto = ackDone && (id_q == INT_RXTO);
    assign clrCfg  = ackDone && (id_q == INT_CFG);
    assign clrTxd  = ackDone && (id_q == INT_TXD);

    // Sticky edge-source flags: a new pulse beats a same-cycle ack clear,
    // and dropping an error enable wipes that flag on the next edge.
    always_comb begin
        ovrPend_d = (bus.overrun_error_i & bus.overrun_error_en_i)
                  | (ovrPend_q & bus.overrun_error_en_i & ~clrOvr);
        parPend_d = (bus.parity_error_i & bus.parity_error_en_i)
                  | (parPend_q & bus.parity_error_en_i & ~clrPar);
        frmPend_d = (bus.frame_error_i & bus.frame_error_en_i)
                  | (frmPend_q & bus.frame_error_en_i & ~clrFrm);
        cfgPend_d = bus.config_req_i | (cfgPend_q & ~clrCfg);
        txdPend_d = bus.tx_done_i    | (txdPend_q & ~clrTxd);
    end

    // State, served ID and pending flags all return to idle values at once
    // when reset asserts, even in the middle of a service.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= IDLE;
            id_q      <= INT_NONE;
            ovrPend_q <= 1'b0;
            parPend_q <= 1'b0;
            frmPend_q <= 1'b0;
            cfgPend_q <= 1'b0;
            txdPend_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            id_q      <= id_d;
            ovrPend_q <= ovrPend_d;
            parPend_q <= parPend_d;
            frmPend_q <= frmPend_d;
            cfgPend_q <= cfgPend_d;
            txdPend_q <= txdPend_d;
        end
    end

endmodule

// File: tb/tb_interrupt_arbiter.sv
// ----------------------------------------------------------------------------
// tb_interrupt_arbiter
// Self-checking bench for interrupt_arbiter: a directed vector table, a few
// hand-written multi-cycle sequences (RX ready, RX timeout when RX_TIMEOUT_EN
// is defined, reset during service) and a randomized run against a
// transaction-level reference model.
// ----------------------------------------------------------------------------
module tb_interrupt_arbiter;
    import interrupt_arbiter_pkg::*;

    logic clk = 1'b0;
    logic rstN;

    always #5 clk = ~clk;

    interrupt_arbiter_if #(.FIFO_DEPTH(64)) bus ();

    interrupt_arbiter dut (
        .clk_i   (clk),
        .rst_n_i (rstN),
        .bus     (bus)
    );

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        logic [4:0] pulse;     // {ovr, par, frm, cfg, txd}
        logic [3:0] en;        // {ovr_en, par_en, frm_en, rx_rdy_en}
        logic       ack;
        logic       expIreqN;
        logic       expPend;
        logic       expIdEn;
        logic [2:0] expId;
    } vec_t;

    vec_t vecs[$];

    // Reference model state: what has happened, not how the RTL stores it.
    bit mPend[8];
    bit mBusy;
    bit mStrobe;
    int mServ;
    int mLastId;
    bit mPrevAck;

    task automatic addVec(input logic [4:0] p, input logic [3:0] e, input logic a,
                          input logic ir, input logic pe, input logic ie, input logic [2:0] id);
        vec_t v;
        v.pulse    = p;
        v.en       = e;
        v.ack      = a;
        v.expIreqN = ir;
        v.expPend  = pe;
        v.expIdEn  = ie;
        v.expId    = id;
        vecs.push_back(v);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clearPulses();
        bus.overrun_error_i = 1'b0;
        bus.parity_error_i  = 1'b0;
        bus.frame_error_i   = 1'b0;
        bus.config_req_i    = 1'b0;
        bus.tx_done_i       = 1'b0;
        bus.rx_push_i       = 1'b0;
        bus.rx_fifo_read_i  = 1'b0;
        bus.bit_tick_i      = 1'b0;
    endtask

    task automatic setEnables(input logic [3:0] e);
        bus.overrun_error_en_i = e[3];
        bus.parity_error_en_i  = e[2];
        bus.frame_error_en_i   = e[1];
        bus.rx_rdy_en_i        = e[0];
    endtask

    task automatic applyStimulus(input vec_t v);
        bus.overrun_error_i = v.pulse[4];
        bus.parity_error_i  = v.pulse[3];
        bus.frame_error_i   = v.pulse[2];
        bus.config_req_i    = v.pulse[1];
        bus.tx_done_i       = v.pulse[0];
        setEnables(v.en);
        bus.int_ackn_i      = v.ack;
        @(negedge clk);
    endtask

    task automatic checkOutput(input string name, input logic expIreqN, input logic expPend,
                               input logic expIdEn, input logic [2:0] expId);
        compared++;
        if (bus.ireq_n_o !== expIreqN || bus.int_pend_o !== expPend ||
            bus.interrupt_id_en_o !== expIdEn || bus.interrupt_id_o !== expId) begin
            mismatched++;
            $display("[TB] FAIL %s: got ireq_n=%b int_pend=%b id_en=%b id=%0d, want ireq_n=%b int_pend=%b id_en=%b id=%0d",
                     name, bus.ireq_n_o, bus.int_pend_o, bus.interrupt_id_en_o, bus.interrupt_id_o,
                     expIreqN, expPend, expIdEn, expId);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < 8; i++) mPend[i] = 1'b0;
        mBusy    = 1'b0;
        mStrobe  = 1'b0;
        mServ    = 0;
        mLastId  = 0;
        mPrevAck = 1'b0;
    endtask

    // One clock edge of the model, using the inputs currently driven.
    task automatic modelStep();
        bit en[8];
        bit pulse[8];
        bit rxLevel;
        bit ackEdge;
        bit found;
        bit req;
        int clrId;
        for (int i = 0; i < 8; i++) begin
            en[i]    = 1'b0;
            pulse[i] = 1'b0;
        end
        en[1] = bus.overrun_error_en_i;
        en[2] = bus.parity_error_en_i;
        en[3] = bus.frame_error_en_i;
        en[6] = 1'b1;
        en[7] = 1'b1;
        pulse[1] = bus.overrun_error_i;
        pulse[2] = bus.parity_error_i;
        pulse[3] = bus.frame_error_i;
        pulse[6] = bus.config_req_i;
        pulse[7] = bus.tx_done_i;
        rxLevel = bus.rx_rdy_en_i && (int'(bus.rx_fifo_count_i) >= int'(bus.rx_fifo_threshold_i))
                  && (bus.rx_fifo_count_i != 0);
        ackEdge = bus.int_ackn_i && !mPrevAck;
        clrId   = 0;
        if (mStrobe) begin
            mStrobe = 1'b0;
        end else if (mBusy) begin
            if (ackEdge) begin
                mBusy = 1'b0;
                clrId = mServ;
            end
        end else begin
            found = 1'b0;
            for (int id = 1; id <= 7; id++) begin
                if (id == 5)      req = rxLevel;
                else if (id == 4) req = 1'b0;
                else              req = mPend[id] && en[id];
                if (req && !found) begin
                    found   = 1'b1;
                    mServ   = id;
                    mLastId = id;
                    mBusy   = 1'b1;
                    mStrobe = 1'b1;
                end
            end
        end
        for (int id = 1; id <= 7; id++) begin
            if (id != 4 && id != 5) begin
                mPend[id] = (pulse[id] && en[id]) || (mPend[id] && en[id] && clrId != id);
            end
        end
        mPrevAck = bus.int_ackn_i;
    endtask

    initial begin
        localparam logic [3:0] EA = 4'b1111;
        localparam logic [3:0] NF = 4'b1101;
        localparam logic [3:0] NP = 4'b1011;

        rstN = 1'b0;
        clearPulses();
        setEnables(4'b0000);
        bus.int_ackn_i          = 1'b0;
        bus.rx_fifo_count_i     = '0;
        bus.rx_fifo_threshold_i = '0;
        step(2);
        checkOutput("reset values", 1'b1, 1'b0, 1'b0, 3'd0);
        rstN = 1'b1;
        step(1);
        checkOutput("idle after reset", 1'b1, 1'b0, 1'b0, 3'd0);

        // PAR served with 2-cycle latency, then acked
        addVec(5'b01000, EA, 0, 1, 0, 0, 3'd0);
        addVec(5'b00000, EA, 0, 0, 1, 1, 3'd2);
        addVec(5'b00000, EA, 0, 0, 1, 0, 3'd2);
        addVec(5'b00000, EA, 1, 1, 0, 0, 3'd2);
        addVec(5'b00000, EA, 1, 1, 0, 0, 3'd2);
        addVec(5'b00000, EA, 0, 1, 0, 0, 3'd2);
        // OVR and TXD together: OVR first, TXD one cycle after IDLE
        addVec(5'b10001, EA, 0, 1, 0, 0, 3'd2);
        addVec(5'b00000, EA, 0, 0, 1, 1, 3'd1);
        addVec(5'b00000, EA, 0, 0, 1, 0, 3'd1);
        addVec(5'b00000, EA, 1, 1, 0, 0, 3'd1);
        addVec(5'b00000, EA, 0, 0, 1, 1, 3'd7);
        addVec(5'b00000, EA, 0, 0, 1, 0, 3'd7);
        addVec(5'b00000, EA, 1, 1, 0, 0, 3'd7);
        addVec(5'b00000, EA, 0, 1, 0, 0, 3'd7);
        // FRM while disabled, then FRM disabled before capture
        addVec(5'b00100, NF, 0, 1, 0, 0, 3'd7);
        addVec(5'b00000, NF, 0, 1, 0, 0, 3'd7);
        addVec(5'b00100, EA, 0, 1, 0, 0, 3'd7);
        addVec(5'b00000, NF, 0, 1, 0, 0, 3'd7);
        addVec(5'b00000, EA, 0, 1, 0, 0, 3'd7);
        // CFG with an ack edge during SERVE that must be ignored
        addVec(5'b00010, EA, 0, 1, 0, 0, 3'd7);
        addVec(5'b00000, EA, 0, 0, 1, 1, 3'd6);
        addVec(5'b00000, EA, 1, 0, 1, 0, 3'd6);
        addVec(5'b00000, EA, 1, 0, 1, 0, 3'd6);
        addVec(5'b00000, EA, 0, 0, 1, 0, 3'd6);
        addVec(5'b00000, EA, 1, 1, 0, 0, 3'd6);
        // PAR served, enable dropped and OVR arrives during WAIT_ACK
        addVec(5'b01000, EA, 0, 1, 0, 0, 3'd6);
        addVec(5'b00000, EA, 0, 0, 1, 1, 3'd2);
        addVec(5'b10000, NP, 0, 0, 1, 0, 3'd2);
        addVec(5'b00000, NP, 1, 1, 0, 0, 3'd2);
        addVec(5'b00000, NP, 0, 0, 1, 1, 3'd1);
        addVec(5'b00000, NP, 0, 0, 1, 0, 3'd1);
        addVec(5'b00000, EA, 1, 1, 0, 0, 3'd1);
        addVec(5'b00000, EA, 0, 1, 0, 0, 3'd1);
        // TXD re-pulsed in the ack cycle: set beats clear
        addVec(5'b00001, EA, 0, 1, 0, 0, 3'd1);
        addVec(5'b00000, EA, 0, 0, 1, 1, 3'd7);
        addVec(5'b00000, EA, 0, 0, 1, 0, 3'd7);
        addVec(5'b00001, EA, 1, 1, 0, 0, 3'd7);
        addVec(5'b00000, EA, 0, 0, 1, 1, 3'd7);
        addVec(5'b00000, EA, 0, 0, 1, 0, 3'd7);
        addVec(5'b00000, EA, 1, 1, 0, 0, 3'd7);
        addVec(5'b00000, EA, 0, 1, 0, 0, 3'd7);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("table[%0d]", i), vecs[i].expIreqN, vecs[i].expPend,
                        vecs[i].expIdEn, vecs[i].expId);
        end

        // RX ready: level source at threshold 8, re-raised while still at 8
        clearPulses();
        setEnables(EA);
        bus.int_ackn_i          = 1'b0;
        bus.rx_fifo_threshold_i = 6'd8;
        for (int i = 1; i <= 8; i++) begin
            bus.rx_fifo_count_i = 7'(i);
            bus.rx_push_i       = 1'b1;
            step(1);
            if (i == 7) checkOutput("rxrdy below threshold", 1'b1, 1'b0, 1'b0, 3'd7);
        end
        bus.rx_push_i = 1'b0;
        checkOutput("rxrdy serve", 1'b0, 1'b1, 1'b1, 3'd5);
        step(1);
        checkOutput("rxrdy wait", 1'b0, 1'b1, 1'b0, 3'd5);
        bus.int_ackn_i = 1'b1;
        step(1);
        checkOutput("rxrdy ack", 1'b1, 1'b0, 1'b0, 3'd5);
        bus.int_ackn_i = 1'b0;
        step(1);
        checkOutput("rxrdy re-raise", 1'b0, 1'b1, 1'b1, 3'd5);
        step(1);
        bus.rx_fifo_count_i = 7'd7;
        bus.rx_fifo_read_i  = 1'b1;
        step(1);
        bus.rx_fifo_read_i  = 1'b0;
        checkOutput("rxrdy wait after read", 1'b0, 1'b1, 1'b0, 3'd5);
        bus.int_ackn_i = 1'b1;
        step(1);
        bus.int_ackn_i = 1'b0;
        step(1);
        checkOutput("rxrdy stays idle", 1'b1, 1'b0, 1'b0, 3'd5);
        step(2);
        checkOutput("rxrdy still idle", 1'b1, 1'b0, 1'b0, 3'd5);

`ifdef RX_TIMEOUT_EN
        // RX timeout: one byte, 640 silent ticks
        bus.rx_fifo_count_i = 7'd1;
        bus.rx_push_i       = 1'b1;
        step(1);
        bus.rx_push_i  = 1'b0;
        bus.bit_tick_i = 1'b1;
        step(639);
        checkOutput("rxto at 639 ticks", 1'b1, 1'b0, 1'b0, 3'd5);
        step(1);
        bus.bit_tick_i = 1'b0;
        step(1);
        checkOutput("rxto serve", 1'b0, 1'b1, 1'b1, 3'd4);
        step(1);
        bus.int_ackn_i = 1'b1;
        step(1);
        bus.int_ackn_i = 1'b0;
        step(2);
        checkOutput("rxto cleared by ack", 1'b1, 1'b0, 1'b0, 3'd4);
        bus.rx_push_i = 1'b1;
        step(1);
        bus.rx_push_i  = 1'b0;
        bus.bit_tick_i = 1'b1;
        step(638);
        bus.rx_fifo_read_i = 1'b1;
        step(1);
        bus.rx_fifo_read_i = 1'b0;
        step(5);
        bus.bit_tick_i = 1'b0;
        step(2);
        checkOutput("rxto read at tick 639", 1'b1, 1'b0, 1'b0, 3'd4);
        bus.rx_fifo_count_i = '0;
`else
        bus.rx_fifo_count_i = '0;
        bus.bit_tick_i      = 1'b1;
        step(700);
        bus.bit_tick_i      = 1'b0;
        checkOutput("no rxto without feature", 1'b1, 1'b0, 1'b0, 3'd5);
`endif
        bus.rx_fifo_count_i = '0;

        // Reset during WAIT_ACK with PAR pending, then a stale ack
        bus.overrun_error_i = 1'b1;
        step(1);
        bus.overrun_error_i = 1'b0;
        step(1);
        checkOutput("ovr serve", 1'b0, 1'b1, 1'b1, 3'd1);
        step(1);
        checkOutput("ovr wait", 1'b0, 1'b1, 1'b0, 3'd1);
        bus.parity_error_i = 1'b1;
        step(1);
        bus.parity_error_i = 1'b0;
        checkOutput("no preemption", 1'b0, 1'b1, 1'b0, 3'd1);
        #3;
        rstN = 1'b0;
        #1;
        checkOutput("async reset", 1'b1, 1'b0, 1'b0, 3'd0);
        bus.int_ackn_i = 1'b1;
        @(negedge clk);
        rstN = 1'b1;
        step(3);
        checkOutput("stale ack after reset", 1'b1, 1'b0, 1'b0, 3'd0);
        bus.int_ackn_i = 1'b0;
        step(2);
        checkOutput("pending cleared by reset", 1'b1, 1'b0, 1'b0, 3'd0);

        // Randomized run against the reference model
        rstN = 1'b0;
        clearPulses();
        setEnables(EA);
        bus.int_ackn_i          = 1'b0;
        bus.rx_fifo_count_i     = '0;
        bus.rx_fifo_threshold_i = 6'($urandom_range(10, 1));
        step(2);
        rstN = 1'b1;
        modelReset();
        step(1);
        for (int c = 0; c < 3000; c++) begin
            bus.overrun_error_i = ($urandom_range(7) == 0);
            bus.parity_error_i  = ($urandom_range(7) == 0);
            bus.frame_error_i   = ($urandom_range(7) == 0);
            bus.config_req_i    = ($urandom_range(9) == 0);
            bus.tx_done_i       = ($urandom_range(9) == 0);
            if ($urandom_range(15) == 0) bus.overrun_error_en_i = ~bus.overrun_error_en_i;
            if ($urandom_range(15) == 0) bus.parity_error_en_i  = ~bus.parity_error_en_i;
            if ($urandom_range(15) == 0) bus.frame_error_en_i   = ~bus.frame_error_en_i;
            if ($urandom_range(31) == 0) bus.rx_rdy_en_i        = ~bus.rx_rdy_en_i;
            if ($urandom_range(3) == 0)  bus.int_ackn_i         = ~bus.int_ackn_i;
            if ($urandom_range(15) == 0) bus.rx_fifo_count_i    = 7'($urandom_range(12));
            modelStep();
            @(negedge clk);
            checkOutput("random", !mBusy, mBusy, mStrobe, 3'(mLastId));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
